// File: rtl/serial_index_stream_pkg.sv
// Shared definitions for the serial index stream and its companion reducers:
// signed sample limits as functions of the sample width, and FSM encodings.
package serial_index_stream_pkg;

    // Controller states: waiting for a command, or streaming a frame.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Most negative two's-complement value of a given width (background).
    function automatic int sample_min(input int width);
        return -(1 <<< (width - 1));
    endfunction

    // Most positive two's-complement value of a given width (peak).
    function automatic int sample_max(input int width);
        return (1 <<< (width - 1)) - 1;
    endfunction

endpackage : serial_index_stream_pkg

// File: rtl/serial_index_stream_frame_counter.sv
// Element counter for one frame: enable-gated up-counter with synchronous
// clear and a terminal flag that marks the final element of the frame.
module frame_counter
    import serial_index_stream_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          terminal
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over increment so a new frame always starts at 0.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    // Frame length is at most 2^CW-1, so limit-1 never needs to wrap for a
    // real frame; a zero limit is never used while emitting.
    assign terminal = (count_q == (limit - CW'(1)));

endmodule : frame_counter

// File: rtl/serial_index_stream.sv
// Accepts (index, length) commands and emits a serial frame of signed
// samples that is MIN everywhere except a single MAX at the commanded index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready, and once the
// output is valid, its sample and flags hold until the transfer completes.
module serial_index_stream
    import serial_index_stream_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int ARGMAX_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ARGMAX_WIDTH-1:0] cmd_index,
    input  logic [ARGMAX_WIDTH-1:0] cmd_len,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    err
);

    localparam logic signed [WIDTH-1:0] S_MIN = WIDTH'(sample_min(WIDTH));
    localparam logic signed [WIDTH-1:0] S_MAX = WIDTH'(sample_max(WIDTH));

    state_e                  state_q;
    state_e                  state_d;
    logic [ARGMAX_WIDTH-1:0] index_q;
    logic [ARGMAX_WIDTH-1:0] index_d;
    logic [ARGMAX_WIDTH-1:0] len_q;
    logic [ARGMAX_WIDTH-1:0] len_d;
    logic                    err_q;
    logic                    err_d;

    logic                    cnt_clr;
    logic                    cnt_en;
    logic [ARGMAX_WIDTH-1:0] cnt;
    logic                    cnt_last;

    frame_counter #(
        .CW(ARGMAX_WIDTH)
    ) u_frame_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .limit    (len_q),
        .count    (cnt),
        .terminal (cnt_last)
    );

    // Next-state and command capture; ready is suppressed while reset is held.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        len_d     = len_q;
        err_d     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cmd_ready = (state_q == ST_IDLE) && !rst;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    index_d = cmd_index;
                    len_d   = cmd_len;
                    cnt_clr = 1'b1;
                    // An empty frame is consumed silently with no error.
                    if (cmd_len != '0) begin
                        state_d = ST_EMIT;
                        err_d   = (cmd_index >= cmd_len);
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample and flags derive only from registered state and count. An
    // out-of-range index never matches the count, so that frame is all MIN.
    always_comb begin
        out_valid = 1'b0;
        out       = S_MIN;
        out_first = 1'b0;
        out_last  = 1'b0;
        if (state_q == ST_EMIT) begin
            out_valid = 1'b1;
            out       = (cnt == index_q) ? S_MAX : S_MIN;
            out_first = (cnt == '0);
            out_last  = cnt_last;
        end
    end

    // Control registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule : serial_index_stream

// File: tb/tb_serial_index_stream.sv
// Bench for serial_index_stream: directed commands, a frame-level reference
// model compared every cycle, and a reducer that checks the peak position.
module tb_serial_index_stream;

    localparam int W    = 4;
    localparam int AW   = 5;
    localparam int MINV = -(2 ** (W - 1));
    localparam int MAXV = (2 ** (W - 1)) - 1;

    logic                 clk;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [AW-1:0]        cmd_index;
    logic [AW-1:0]        cmd_len;
    logic signed [W-1:0]  out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_first;
    logic                 out_last;
    logic                 err;

    serial_index_stream #(
        .WIDTH        (W),
        .ARGMAX_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_index (cmd_index),
        .cmd_len   (cmd_len),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_int(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int val;
        bit first;
        bit last;
        int idx;
        bit inrange;
    } samp_t;

    samp_t exp_q[$];
    bit    exp_err  = 1'b0;
    bit    checking = 1'b0;

    // Observed handshaken samples, cleared per test.
    int    got_q[$];
    int    first_cnt = 0;
    int    last_cnt  = 0;
    int    first_pos = -1;
    int    last_pos  = -1;
    int    first_cyc = 0;
    int    last_cyc  = 0;
    int    err_seen  = 0;

    // Serial argmax reducer fed from the DUT stream.
    int    best_val  = 0;
    int    best_idx  = 0;
    int    pos       = 0;
    int    cl_frames = 0;

    task automatic push_frame(input int idx, input int len);
        samp_t s;
        for (int p = 0; p < len; p++) begin
            s.val     = (p == idx) ? MAXV : MINV;
            s.first   = (p == 0);
            s.last    = (p == len - 1);
            s.idx     = idx;
            s.inrange = (idx < len);
            exp_q.push_back(s);
        end
    endtask

    // Compare outputs with the model, then advance the model across the
    // coming clock edge using the inputs that edge will see.
    always @(negedge clk) begin
        samp_t s;
        bit    busy;
        if (checking) begin
            busy = (exp_q.size() != 0);
            check_int("out_valid", out_valid, busy);
            if (busy) begin
                check_int("out", out, exp_q[0].val);
                check_int("out_first", out_first, exp_q[0].first);
                check_int("out_last", out_last, exp_q[0].last);
            end else begin
                check_int("out_idle", out, MINV);
                check_int("out_first_idle", out_first, 0);
                check_int("out_last_idle", out_last, 0);
            end
            check_int("cmd_ready", cmd_ready, (!busy && !rst));
            check_int("err", err, exp_err);
            if (err === 1'b1) err_seen++;

            if (rst) begin
                exp_q.delete();
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b0;
                if (busy && out_ready) begin
                    s = exp_q.pop_front();
                    if (out_first) begin
                        first_cnt++;
                        first_pos = got_q.size();
                        first_cyc = cyc;
                        best_val  = out;
                        best_idx  = 0;
                        pos       = 0;
                    end else begin
                        pos++;
                        if (int'(out) > best_val) begin
                            best_val = out;
                            best_idx = pos;
                        end
                    end
                    if (out_last) begin
                        last_cnt++;
                        last_pos = got_q.size();
                        last_cyc = cyc;
                        if (s.inrange) begin
                            check_int("argmax", best_idx, s.idx);
                            cl_frames++;
                        end
                    end
                    got_q.push_back(out);
                end else if (!busy && cmd_valid) begin
                    if (cmd_len != '0) begin
                        push_frame(cmd_index, cmd_len);
                        exp_err = (cmd_index >= cmd_len);
                    end
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_capture();
        got_q.delete();
        first_pos = -1;
        last_pos  = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_cmd(input int idx, input int len);
        int n = 0;
        cmd_index = AW'(idx);
        cmd_len   = AW'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        #1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_int("cmd_accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Returns at posedge+1 of the cycle right after the last handshake.
    task automatic wait_frame_done();
        int l0 = last_cnt;
        int n  = 0;
        while (last_cnt == l0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_int("frame_done_timeout", (last_cnt != l0), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int exp_vals[], input int len);
        check_int({name, "_len"}, got_q.size(), len);
        for (int i = 0; i < len && i < got_q.size(); i++) begin
            check_int(name, got_q[i], exp_vals[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t1[];
        int t4[];
        int t5[];
        int e0;
        int l0;
        int c0;
        int n;

        t1 = '{-8, -8, -8, 7, -8, -8, -8, -8};
        t4 = '{-8, -8, -8, -8, -8};
        t5 = '{-8, -8, 7, -8};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state, sampled while reset is still held.
        check_int("rst_out_valid", out_valid, 0);
        check_int("rst_out", out, -8);
        check_int("rst_out_first", out_first, 0);
        check_int("rst_out_last", out_last, 0);
        check_int("rst_err", err, 0);
        check_int("rst_cmd_ready", cmd_ready, 0);
        checking = 1'b1;
        rst = 1'b0;
        #1;
        check_int("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Peak at index 3 of 8, no back-pressure.
        clear_capture();
        send_cmd(3, 8);
        wait_frame_done();
        check_frame("t1_sample", t1, 8);
        check_int("t1_first_pos", first_pos, 0);
        check_int("t1_last_pos", last_pos, 7);
        check_int("t1_span", last_cyc - first_cyc, 7);
        check_int("t1_ready_after", cmd_ready, 1);

        // Same frame with stalls on the output.
        rdy_mode = 1;
        clear_capture();
        send_cmd(3, 8);
        wait_frame_done();
        rdy_mode = 0;
        check_frame("t2_sample", t1, 8);
        check_int("t2_first_pos", first_pos, 0);
        check_int("t2_last_pos", last_pos, 7);

        // Single-sample frame, then an empty command.
        clear_capture();
        send_cmd(0, 1);
        wait_frame_done();
        check_int("t3_len", got_q.size(), 1);
        if (got_q.size() > 0) check_int("t3_sample", got_q[0], 7);
        check_int("t3_first_pos", first_pos, 0);
        check_int("t3_last_pos", last_pos, 0);
        clear_capture();
        e0 = err_seen;
        send_cmd(5, 0);
        repeat (4) @(posedge clk);
        #1;
        check_int("t3_empty_samples", got_q.size(), 0);
        check_int("t3_empty_err", err_seen - e0, 0);
        check_int("t3_empty_ready", cmd_ready, 1);
        check_int("t3_empty_valid", out_valid, 0);

        // Out-of-range index: one error pulse, all-background frame.
        clear_capture();
        e0 = err_seen;
        send_cmd(9, 5);
        wait_frame_done();
        check_int("t4_err_pulses", err_seen - e0, 1);
        check_frame("t4_sample", t4, 5);

        // Reset while the 4th sample of a 20-sample frame is presented.
        clear_capture();
        l0 = last_cnt;
        send_cmd(10, 20);
        n = 0;
        while (got_q.size() < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("t5_reach_4th", got_q.size(), 3);
        check_int("t5_4th_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_int("t5_abort_valid", out_valid, 0);
        check_int("t5_abort_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_int("t5_ready_after_rst", cmd_ready, 1);
        check_int("t5_no_last", last_cnt - l0, 0);
        check_int("t5_samples_before_abort", got_q.size(), 3);
        @(posedge clk);
        #1;
        clear_capture();
        send_cmd(2, 4);
        wait_frame_done();
        check_int("t5_restart_first_pos", first_pos, 0);
        check_frame("t5_restart", t5, 4);

        // Closed loop: every peak position in a maximum-length frame.
        c0 = cl_frames;
        for (int i = 0; i < 31; i++) begin
            send_cmd(i, 31);
            wait_frame_done();
        end
        check_int("t6_frames", cl_frames - c0, 31);

        repeat (3) @(posedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung handshake.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_index_stream
